// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Also holds the modulo-increment helper used for round-robin pointers.
package sram_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int REQ_INCOPY = 0;
    localparam int REQ_ENGINE = 1;
    localparam int REQ_DBG    = 2;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 64;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational one-hot picker: first eligible request at or after ptr, wrapping.
// A zero pointer turns it into a plain lowest-index priority encoder.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         mask,
    output logic [N-1:0]         pick
);

    logic [N-1:0] elig;
    logic         found;
    int           idx;

    always_comb begin
        elig  = req & mask;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Per-cycle arbiter sharing one single-port SRAM among NREQ requesters,
// with bounded burst lock and read-data return to the issuing requester.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_LOCK = 16
) (
    input  logic                    axi_clk,
    input  logic                    rst,
    input  logic                    cfg_fixed_prio,
    input  logic [NREQ-1:0]         req_en,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*AW-1:0]      req_adr,
    input  logic [NREQ*DW-1:0]      req_d,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvld,
    output logic [DW-1:0]           rdata,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [AW-1:0]           ram_adr,
    output logic [DW-1:0]           ram_d,
    input  logic [DW-1:0]           ram_q,
    output logic [$clog2(NREQ)-1:0] lock_owner,
    output logic                    locked
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e      state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt, lock_owner_nxt, rd_owner, blk_owner, start_ptr, gidx;
    logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
    logic            rd_pend, blk_relock, forced, owner_hold, may_lock;
    logic [NREQ-1:0] owner_oh, pick_mask, pick;

    assign owner_oh   = NREQ'(1) << lock_owner;
    assign forced     = (state == LOCK) && (lock_cnt >= CW'(MAX_LOCK));
    assign owner_hold = (state == LOCK) && !forced && req_en[lock_owner] && req_lock[lock_owner];
    // On a forced release the owner only gets the slot if nobody else wants it.
    assign pick_mask  = forced ? ~owner_oh : '1;
    assign start_ptr  = cfg_fixed_prio ? '0 : rr_ptr;

    rr_pick #(.N(NREQ)) u_pick (
        .req  (req_en),
        .ptr  (start_ptr),
        .mask (pick_mask),
        .pick (pick)
    );

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (owner_hold)                        gnt = owner_oh;
            else if (|pick)                        gnt = pick;
            else if (forced && req_en[lock_owner]) gnt = owner_oh;
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) gidx = IW'(i);
    end

    assign ram_en  = |gnt;
    assign ram_we  = ram_en & req_we[gidx];
    assign ram_adr = ram_en ? req_adr[int'(gidx)*AW +: AW] : '0;
    assign ram_d   = ram_en ? req_d[int'(gidx)*DW +: DW] : '0;
    assign rvld    = (rd_pend && !rst) ? (NREQ'(1) << rd_owner) : '0;
    assign rdata   = ram_q;
    assign locked  = (state == LOCK);

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_owner_nxt = lock_owner;
        lock_cnt_nxt   = lock_cnt;
        may_lock       = req_lock[gidx]
                         && !(forced && gidx == lock_owner)
                         && !(blk_relock && gidx == blk_owner);
        if (owner_hold) begin
            lock_cnt_nxt = lock_cnt + 1'b1;
        end else begin
            state_nxt    = ARB;
            lock_cnt_nxt = '0;
            if (forced)      rr_ptr_nxt = IW'(wrap_inc(int'(lock_owner), NREQ));
            else if (ram_en) rr_ptr_nxt = IW'(wrap_inc(int'(gidx), NREQ));
            if (ram_en && may_lock) begin
                state_nxt      = LOCK;
                lock_owner_nxt = gidx;
                lock_cnt_nxt   = CW'(1);
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state      <= ARB;
            rr_ptr     <= '0;
            lock_owner <= '0;
            lock_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= '0;
            blk_relock <= 1'b0;
            blk_owner  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock_owner <= lock_owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
            rd_pend    <= ram_en & ~ram_we;
            rd_owner   <= gidx;
            blk_relock <= forced;
            blk_owner  <= lock_owner;
        end
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 1024x64 SRAM macro (1-cycle registered read) among NREQ requesters.
- Requesters: stream input copier, FFT/NTT engine, AXI-lite debug reader.
- Replaces the hard state-based muxing in USER_PRJ1 with a per-cycle arbiter:
  - round-robin or fixed priority;
  - bounded burst lock;
  - read-return routing to the issuing requester.
- Sits between the requesters and the SRAM wrapper. The top level inverts en/we for the active-low macro pins.

Parameters:
- NREQ, 3, number of requesters (index 0 = highest fixed priority).
- AW, 10, SRAM address width.
- DW, 64, SRAM data width.
- MAX_LOCK, 16, maximum consecutive grants to a locking requester (must be ≥ 2).

Ports:
- axi_clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- cfg_fixed_prio, in, 1: 0 = round-robin, 1 = fixed priority; sampled every cycle.
- req_en, in, NREQ, per-requester access request.
- req_we, in, NREQ, per-requester write (1) / read (0).
- req_lock, in, NREQ, request to keep the grant on following cycles.
- req_adr, in, NREQ*AW, flattened addresses (requester i at [i*AW +: AW]).
- req_d, in, NREQ*DW, flattened write data.
- gnt, out, NREQ, one-hot combinational grant; the access happens this cycle.
- rvld, out, NREQ, one-hot read-data-valid, one cycle after a granted read.
- rdata, out, DW, read data (ram_q pass-through).
- ram_en, out, 1, SRAM enable, active high.
- ram_we, out, 1, SRAM write enable, active high.
- ram_adr, out, AW, SRAM address.
- ram_d, out, DW, SRAM write data.
- ram_q, in, DW, SRAM read data, valid one cycle after a read enable.
- lock_owner, out, 2 (clog2 NREQ), current lock holder index (debug/status).
- locked, out, 1, 1 while in the LOCK state.

Behaviour:
- One clock (axi_clk); reset is synchronous and active-high (rst). All state updates on the posedge axi_clk.
- Reset values:
  - rr_ptr=0, state ARB, lock_cnt=0, rvld=0, rd_owner=0, locked=0, lock_owner=0.
  - gnt=0, ram_en=0 and ram_we=0 while rst is high, regardless of req_en.
- Grant is combinational from req_en and the registered state:
  - At most one gnt bit is set.
  - gnt is 0 when req_en is 0.
  - ram_en = |gnt. ram_we, ram_adr and ram_d are muxed from the granted requester.
  - When ram_en=0, ram_we=0 and ram_adr/ram_d are held 0.
- ARB state:
  - cfg_fixed_prio=1: the lowest-index requester with req_en wins.
  - cfg_fixed_prio=0: search starts at rr_ptr and wraps modulo NREQ. After a grant to i, rr_ptr <= (i+1) mod NREQ.
  - If the winner also has req_lock=1: go to LOCK, lock_owner <= i, lock_cnt <= 1.
- LOCK state:
  - The owner wins unconditionally while req_en[owner] & req_lock[owner]; lock_cnt increments each granted cycle.
  - Exit to ARB (same-cycle fallback to ARB selection) when the owner drops req_en or req_lock.
  - Forced exit when lock_cnt reaches MAX_LOCK:
    - that cycle is arbitrated as ARB with the owner masked out;
    - the owner is granted only if no other requester is active;
    - rr_ptr <= owner+1.
  - No re-lock by the same owner on the cycle right after a forced release.
- Read return:
  - On a granted read, rd_owner <= i and rd_pend <= 1.
  - Next cycle rvld[rd_owner]=1 and rdata=ram_q.
  - Back-to-back reads pipeline with 1 read per cycle; rvld is never stalled.
- Write: completes in the grant cycle; no response.
- Starvation bound in round-robin mode: a requester holding req_en is granted within (NREQ-1)*MAX_LOCK + NREQ cycles.
- cfg_fixed_prio changes take effect the same cycle. A LOCK in progress is honoured in both modes.
- Reset mid-operation: a pending rvld is dropped (rvld=0 the cycle after rst asserts) and the lock is cleared.

Decomposition:
- Shared package (sram_arb_pkg):
  - state encoding ARB=1'b0, LOCK=1'b1;
  - requester index constants REQ_INCOPY=0, REQ_ENGINE=1, REQ_DBG=2;
  - default AW/DW.
- One sub-module: rr_pick, a combinational rotate-priority one-hot picker.
  - Inputs: request vector, start pointer, mask.
  - Used for both the round-robin and the fixed-priority (pointer=0) paths.

Test Plan:
- Reset: rst=1 with req_en=3'b111 → gnt=0, ram_en=0, rvld=0. After release, round-robin first grant goes to req0.
- Round-robin: req_en=3'b111 continuously, no lock → gnt sequence 001,010,100,001…; ram_adr follows the granted req_adr.
- Read return: req1 reads adr 10'h05 after req0 wrote 64'hDEAD_BEEF_0123_4567 there → next cycle rvld=3'b010 and rdata=64'hDEAD_BEEF_0123_4567. Back-to-back reads by req0 then req2 → rvld 001 then 100.
- Lock bound: req0 lock held, req1 requesting, MAX_LOCK=16 → req0 granted 16 consecutive cycles, then req1 granted on cycle 17.
- Fixed priority: cfg_fixed_prio=1, req_en=3'b110 → req1 granted every cycle; req2 never granted until req1 drops.
- Reset mid-read: read granted in cycle N, rst=1 in cycle N+1 → rvld stays 0; locked=0 after reset.
